// File: rtl/mem_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mem_ctrl_pkg
//   Shared definitions for the memory-port arbiter/sequencer: access-length
//   encodings, the default IO window base, FSM state and owner encodings, and
//   a helper that turns an access length into a byte count.
// -----------------------------------------------------------------------------
package mem_ctrl_pkg;

    // Addresses at or above this value are memory-mapped IO.
    localparam logic [31:0] IO_BASE_DEFAULT = 32'h0003_0000;

    // LSB access-length encodings.
    localparam logic [1:0] MEM_LEN_BYTE = 2'd0;
    localparam logic [1:0] MEM_LEN_HALF = 2'd1;
    localparam logic [1:0] MEM_LEN_WORD = 2'd2;

    typedef enum logic [1:0] {
        MC_IDLE = 2'd0,
        MC_RD   = 2'd1,
        MC_WR   = 2'd2
    } mc_state_e;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_LSB = 1'b1
    } mc_owner_e;

    // Length 3 is illegal and is handled as a full word.
    function automatic logic [2:0] len_to_nbytes(input logic [1:0] len);
        case (len)
            MEM_LEN_BYTE: return 3'd1;
            MEM_LEN_HALF: return 3'd2;
            default:      return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// -----------------------------------------------------------------------------
// mem_ctrl
//   Arbiter and byte sequencer for the single byte-wide RAM/IO port shared by
//   the instruction fetcher (IF) and the load/store buffer (LSB). One requester
//   is granted at a time (round-robin when both are pending); the granted
//   1/2/4-byte access is then issued one byte per cycle. Read data is
//   assembled little-endian and returned zero-extended.
//
// Ports
//   clk_in, rst_in        clock, asynchronous active-high reset
//   rdy_in                0 = freeze all state and outputs
//   rob_clear             flush: aborts an in-flight read, ignores new requests
//   io_buffer_full        stalls writes into the IO window
//   mem_din/mem_dout/mem_a/mem_wr   external byte port
//   if_req/if_addr -> if_done/if_data               4-byte instruction fetch
//   lsb_req/lsb_wr/lsb_len/lsb_addr/lsb_wdata -> lsb_done/lsb_rdata
// -----------------------------------------------------------------------------
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter logic [31:0] IO_BASE = IO_BASE_DEFAULT
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        rob_clear,
    input  logic        io_buffer_full,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        lsb_req,
    input  logic        lsb_wr,
    input  logic [1:0]  lsb_len,
    input  logic [31:0] lsb_addr,
    input  logic [31:0] lsb_wdata,
    output logic        lsb_done,
    output logic [31:0] lsb_rdata
);

    mc_state_e   state_q, state_d;
    mc_owner_e   owner_q, owner_d;
    mc_owner_e   last_grant_q, last_grant_d;
    logic [2:0]  cnt_q, cnt_d;         // bytes issued on the port so far
    logic [2:0]  rcnt_q, rcnt_d;       // read bytes captured so far
    logic        pend_q, pend_d;       // mem_din carries a requested byte this cycle
    logic [2:0]  nbytes_q, nbytes_d;
    logic [31:0] addr_q, addr_d;       // next byte address to issue
    logic [31:0] wbuf_q, wbuf_d;
    logic [31:0] rbuf_q, rbuf_d;
    logic [31:0] mem_a_q, mem_a_d;
    logic [7:0]  mem_dout_q, mem_dout_d;
    logic        wr_q, wr_d;
    logic        if_done_q, if_done_d;
    logic [31:0] if_data_q, if_data_d;
    logic        lsb_done_q, lsb_done_d;
    logic [31:0] lsb_rdata_q, lsb_rdata_d;

    logic        stall;
    logic        if_v, lsb_v, grant_lsb;
    logic [31:0] start_addr;
    logic [31:0] rbuf_ins;

    // The IO stall acts in the same cycle the byte is presented, so mem_wr is
    // gated combinationally rather than registered.
    assign stall = wr_q && io_buffer_full && (mem_a_q >= IO_BASE);

    assign mem_a     = mem_a_q;
    assign mem_dout  = mem_dout_q;
    assign mem_wr    = wr_q && !stall;
    assign if_done   = if_done_q;
    assign if_data   = if_data_q;
    assign lsb_done  = lsb_done_q;
    assign lsb_rdata = lsb_rdata_q;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        rcnt_d       = rcnt_q;
        pend_d       = pend_q;
        nbytes_d     = nbytes_q;
        addr_d       = addr_q;
        wbuf_d       = wbuf_q;
        rbuf_d       = rbuf_q;
        mem_a_d      = mem_a_q;
        mem_dout_d   = mem_dout_q;
        wr_d         = wr_q;
        if_done_d    = 1'b0;
        if_data_d    = if_data_q;
        lsb_done_d   = 1'b0;
        lsb_rdata_d  = lsb_rdata_q;

        // A requester still seeing its own done pulse has not yet dropped req.
        if_v       = if_req  && !if_done_q  && !rob_clear;
        lsb_v      = lsb_req && !lsb_done_q && !rob_clear;
        grant_lsb  = lsb_v && (!if_v || last_grant_q == OWN_IF);
        start_addr = grant_lsb ? lsb_addr : if_addr;

        rbuf_ins = rbuf_q;
        if (pend_q) rbuf_ins[{rcnt_q[1:0], 3'b000} +: 8] = mem_din;

        case (state_q)
            MC_IDLE: begin
                mem_a_d = '0;
                wr_d    = 1'b0;
                if (if_v || lsb_v) begin
                    owner_d      = grant_lsb ? OWN_LSB : OWN_IF;
                    last_grant_d = grant_lsb ? OWN_LSB : OWN_IF;
                    nbytes_d     = grant_lsb ? len_to_nbytes(lsb_len) : 3'd4;
                    mem_a_d      = start_addr;
                    addr_d       = start_addr + 32'd1;
                    cnt_d        = 3'd1;
                    rcnt_d       = '0;
                    pend_d       = 1'b0;
                    rbuf_d       = '0;
                    wbuf_d       = lsb_wdata;
                    if (grant_lsb && lsb_wr) begin
                        state_d    = MC_WR;
                        wr_d       = 1'b1;
                        mem_dout_d = lsb_wdata[7:0];
                    end else begin
                        state_d = MC_RD;
                    end
                end
            end

            MC_RD: begin
                if (rob_clear) begin
                    state_d = MC_IDLE;
                    mem_a_d = '0;
                    pend_d  = 1'b0;
                end else begin
                    rbuf_d = rbuf_ins;
                    rcnt_d = rcnt_q + {2'b00, pend_q};
                    // The address on the port now is a real one if more bytes
                    // have been issued than already captured or arriving.
                    pend_d = cnt_q > (rcnt_q + {2'b00, pend_q});
                    if (cnt_q < nbytes_q) begin
                        mem_a_d = addr_q;
                        addr_d  = addr_q + 32'd1;
                        cnt_d   = cnt_q + 3'd1;
                    end else begin
                        mem_a_d = '0;
                    end
                    if (pend_q && rcnt_d == nbytes_q) begin
                        state_d = MC_IDLE;
                        mem_a_d = '0;
                        pend_d  = 1'b0;
                        if (owner_q == OWN_IF) begin
                            if_done_d = 1'b1;
                            if_data_d = rbuf_ins;
                        end else begin
                            lsb_done_d  = 1'b1;
                            lsb_rdata_d = rbuf_ins;
                        end
                    end
                end
            end

            MC_WR: begin
                // Stores are committed; rob_clear does not abort them.
                if (!stall) begin
                    if (cnt_q < nbytes_q) begin
                        mem_a_d    = addr_q;
                        addr_d     = addr_q + 32'd1;
                        mem_dout_d = wbuf_q[{cnt_q[1:0], 3'b000} +: 8];
                        cnt_d      = cnt_q + 3'd1;
                    end else begin
                        state_d    = MC_IDLE;
                        mem_a_d    = '0;
                        wr_d       = 1'b0;
                        lsb_done_d = 1'b1;
                    end
                end
            end

            default: state_d = MC_IDLE;
        endcase
    end

    // NOTE: state is updated only with non-blocking assignments so every flop
    // samples the values from before this edge.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q      <= MC_IDLE;
            owner_q      <= OWN_IF;
            last_grant_q <= OWN_IF;
            cnt_q        <= '0;
            rcnt_q       <= '0;
            pend_q       <= 1'b0;
            nbytes_q     <= '0;
            addr_q       <= '0;
            wbuf_q       <= '0;
            rbuf_q       <= '0;
            mem_a_q      <= '0;
            mem_dout_q   <= '0;
            wr_q         <= 1'b0;
            if_done_q    <= 1'b0;
            if_data_q    <= '0;
            lsb_done_q   <= 1'b0;
            lsb_rdata_q  <= '0;
        end else if (rdy_in) begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            rcnt_q       <= rcnt_d;
            pend_q       <= pend_d;
            nbytes_q     <= nbytes_d;
            addr_q       <= addr_d;
            wbuf_q       <= wbuf_d;
            rbuf_q       <= rbuf_d;
            mem_a_q      <= mem_a_d;
            mem_dout_q   <= mem_dout_d;
            wr_q         <= wr_d;
            if_done_q    <= if_done_d;
            if_data_q    <= if_data_d;
            lsb_done_q   <= lsb_done_d;
            lsb_rdata_q  <= lsb_rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_ctrl
//   Directed bench for mem_ctrl. A byte-memory model answers each address one
//   cycle later; every expected value is written out by hand below.
// -----------------------------------------------------------------------------
module tb_mem_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        rob_clear;
    logic        io_buffer_full;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;
    logic        lsb_req;
    logic        lsb_wr;
    logic [1:0]  lsb_len;
    logic [31:0] lsb_addr;
    logic [31:0] lsb_wdata;
    logic        lsb_done;
    logic [31:0] lsb_rdata;

    int n_checks = 0;
    int n_errors = 0;

    mem_ctrl dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .rob_clear     (rob_clear),
        .io_buffer_full(io_buffer_full),
        .mem_din       (mem_din),
        .mem_dout      (mem_dout),
        .mem_a         (mem_a),
        .mem_wr        (mem_wr),
        .if_req        (if_req),
        .if_addr       (if_addr),
        .if_done       (if_done),
        .if_data       (if_data),
        .lsb_req       (lsb_req),
        .lsb_wr        (lsb_wr),
        .lsb_len       (lsb_len),
        .lsb_addr      (lsb_addr),
        .lsb_wdata     (lsb_wdata),
        .lsb_done      (lsb_done),
        .lsb_rdata     (lsb_rdata)
    );

    always #5 clk_in = ~clk_in;

    // Byte memory: unwritten locations read back as the low address byte.
    logic [7:0] mem_bytes [logic [31:0]];

    function automatic logic [7:0] rd_byte(input logic [31:0] a);
        if (mem_bytes.exists(a)) return mem_bytes[a];
        return a[7:0];
    endfunction

    always @(posedge clk_in) mem_din <= rd_byte(mem_a);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to the next cycle; inputs and outputs are handled 1 time unit
    // after the rising edge.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; rob_clear = 1'b0; io_buffer_full = 1'b0;
        if_req = 1'b0; if_addr = '0;
        lsb_req = 1'b0; lsb_wr = 1'b0; lsb_len = '0; lsb_addr = '0; lsb_wdata = '0;
        mem_bytes[32'h100] = 8'h11; mem_bytes[32'h101] = 8'h22;
        mem_bytes[32'h102] = 8'h33; mem_bytes[32'h103] = 8'h44;
        mem_bytes[32'h305] = 8'h80;
        #1;
        check("rst_mem_a",    mem_a,     32'h0);
        check("rst_mem_wr",   mem_wr,    32'h0);
        check("rst_mem_dout", mem_dout,  32'h0);
        check("rst_if_done",  if_done,   32'h0);
        check("rst_lsb_done", lsb_done,  32'h0);
        check("rst_if_data",  if_data,   32'h0);
        check("rst_lsb_rd",   lsb_rdata, 32'h0);
        tick(); tick();
        rst_in = 1'b0;
        tick();

        // 1. IF read of 0x100: addresses in cycles 1-4, done in cycle 6.
        if_req = 1'b1; if_addr = 32'h100;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("t1_mem_a_c%0d", k + 1), mem_a, 32'h100 + k);
            check($sformatf("t1_mem_wr_c%0d", k + 1), mem_wr, 32'h0);
        end
        tick();
        check("t1_gap_mem_a", mem_a, 32'h0);
        check("t1_no_done_c5", if_done, 32'h0);
        tick();
        check("t1_if_done", if_done, 32'h1);
        check("t1_if_data", if_data, 32'h4433_2211);
        check("t1_lsb_quiet", lsb_done, 32'h0);
        if_req = 1'b0;
        tick();
        check("t1_done_pulse", if_done, 32'h0);

        // 3. Both pending with last grant IF: LSB first, then IF, then LSB.
        if_req = 1'b1; if_addr = 32'h100;
        lsb_req = 1'b1; lsb_wr = 1'b0; lsb_len = 2'd2; lsb_addr = 32'h400;
        tick();
        check("t3_first_lsb", mem_a, 32'h400);
        tick(); tick(); tick(); tick(); tick();              // cycle 6
        check("t3_lsb_done", lsb_done, 32'h1);
        check("t3_lsb_rdata", lsb_rdata, 32'h0302_0100);
        check("t3_if_wait", if_done, 32'h0);
        lsb_req = 1'b0;
        tick();                                               // cycle 7
        check("t3_then_if", mem_a, 32'h100);
        tick(); tick(); tick(); tick(); tick();              // cycle 12
        check("t3_if_done", if_done, 32'h1);
        check("t3_if_data", if_data, 32'h4433_2211);
        if_req = 1'b0;
        tick();                                               // cycle 13
        if_req = 1'b1; lsb_req = 1'b1;
        tick();                                               // cycle 14
        check("t3_third_lsb", mem_a, 32'h400);
        tick(); tick(); tick(); tick(); tick();              // cycle 19
        check("t3_lsb_done2", lsb_done, 32'h1);
        lsb_req = 1'b0;
        tick();                                               // cycle 20
        check("t3_if_again", mem_a, 32'h100);
        tick(); tick(); tick(); tick(); tick();              // cycle 25
        check("t3_if_done2", if_done, 32'h1);
        if_req = 1'b0;
        tick();

        // 2. Store word 0xDEADBEEF at 0x200: write cycles 1-4, done cycle 5.
        lsb_req = 1'b1; lsb_wr = 1'b1; lsb_len = 2'd2;
        lsb_addr = 32'h200; lsb_wdata = 32'hDEAD_BEEF;
        for (int k = 0; k < 4; k++) begin
            logic [31:0] wd;
            wd = 32'hDEAD_BEEF;
            tick();
            check($sformatf("t2_wr_c%0d", k + 1), mem_wr, 32'h1);
            check($sformatf("t2_a_c%0d", k + 1), mem_a, 32'h200 + k);
            check($sformatf("t2_dout_c%0d", k + 1), mem_dout, wd[8*k +: 8]);
            check($sformatf("t2_nodone_c%0d", k + 1), lsb_done, 32'h0);
        end
        tick();
        check("t2_lsb_done", lsb_done, 32'h1);
        check("t2_wr_low", mem_wr, 32'h0);
        lsb_req = 1'b0;
        tick();

        // 4. Load byte at 0x305 holding 0x80: zero-extended, done cycle 3.
        lsb_req = 1'b1; lsb_wr = 1'b0; lsb_len = 2'd0; lsb_addr = 32'h305;
        tick();
        check("t4_mem_a", mem_a, 32'h305);
        tick();
        check("t4_gap", mem_a, 32'h0);
        tick();
        check("t4_lsb_done", lsb_done, 32'h1);
        check("t4_lsb_rdata", lsb_rdata, 32'h0000_0080);
        // Freeze while the done pulse is up: it must be held, then drop.
        lsb_req = 1'b0; rdy_in = 1'b0;
        tick();
        check("rdy_hold1", lsb_done, 32'h1);
        tick();
        check("rdy_hold2", lsb_done, 32'h1);
        rdy_in = 1'b1;
        tick();
        check("rdy_release", lsb_done, 32'h0);

        // 5. IF read flushed in cycle 3; a new request in cycle 5 completes.
        if_req = 1'b1; if_addr = 32'h100;
        tick(); tick(); tick();                               // cycle 3
        rob_clear = 1'b1;
        tick();                                               // cycle 4
        rob_clear = 1'b0;
        check("t5_flush_mem_a", mem_a, 32'h0);
        check("t5_no_done_c4", if_done, 32'h0);
        if_req = 1'b0;
        tick();                                               // cycle 5
        check("t5_no_done_c5", if_done, 32'h0);
        if_req = 1'b1;
        tick();                                               // cycle 6
        check("t5_restart", mem_a, 32'h100);
        tick(); tick(); tick(); tick(); tick();              // cycle 11
        check("t5_if_done", if_done, 32'h1);
        check("t5_if_data", if_data, 32'h4433_2211);
        if_req = 1'b0;
        tick();

        // 6. IO byte store stalled in cycles 1-3; second pass adds rob_clear.
        for (int pass = 0; pass < 2; pass++) begin
            lsb_req = 1'b1; lsb_wr = 1'b1; lsb_len = 2'd0;
            lsb_addr = 32'h0003_0000; lsb_wdata = 32'h0000_005A;
            for (int c = 1; c <= 3; c++) begin
                tick();
                io_buffer_full = 1'b1;
                rob_clear      = (pass == 1 && c == 2);
                #1;
                check($sformatf("t6_p%0d_stall_c%0d", pass, c), mem_wr, 32'h0);
            end
            tick();                                           // cycle 4
            io_buffer_full = 1'b0; rob_clear = 1'b0;
            #1;
            check($sformatf("t6_p%0d_wr", pass), mem_wr, 32'h1);
            check($sformatf("t6_p%0d_a", pass), mem_a, 32'h0003_0000);
            check($sformatf("t6_p%0d_dout", pass), mem_dout, 32'h5A);
            tick();                                           // cycle 5
            check($sformatf("t6_p%0d_done", pass), lsb_done, 32'h1);
            check($sformatf("t6_p%0d_wr_low", pass), mem_wr, 32'h0);
            lsb_req = 1'b0;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
